// File: rtl/fp_mac_pkg.sv
// Shared widths, FP constants and the dot-product sequencer state encoding
// for the fp_mac datapath.
package fp_mac_pkg;

   localparam int unsigned FP16_W = 16;
   localparam int unsigned FP32_W = 32;

   localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
   localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } dot_state_t;

endpackage

// File: rtl/fp_dot_seq.sv
// Sequences FP16 operand pairs through an external fp_mac, feeding each Y back
// as the next C, and presents the final FP32 accumulator on a valid/ready port.
module fp_dot_seq
   import fp_mac_pkg::*;
#(
   parameter int unsigned MAC_LAT = 2,
   parameter int unsigned LEN_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [FP32_W-1:0] bias,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP16_W-1:0] in_a,
   input  logic [FP16_W-1:0] in_b,
   output logic [FP16_W-1:0] mac_a,
   output logic [FP16_W-1:0] mac_b,
   output logic [FP32_W-1:0] mac_c,
   input  logic [FP32_W-1:0] mac_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP32_W-1:0] out_y
);

   localparam int unsigned CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MAC_LAT - 1);

   dot_state_t        state;
   logic [FP32_W-1:0] acc;
   logic [LEN_W-1:0]  rem;
   logic [CNT_W-1:0]  lat_cnt;

   // Handshake qualifiers are pure state decodes so ready never depends on valid.
   assign busy      = (state != IDLE);
   assign in_ready  = (state == ISSUE);
   assign out_valid = (state == DONE);
   assign out_y     = acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= FP32_ZERO;
         rem     <= '0;
         lat_cnt <= '0;
         mac_a   <= '0;
         mac_b   <= '0;
         mac_c   <= FP32_ZERO;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= bias;
                  rem   <= len;
                  state <= (len == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (in_valid) begin
                  mac_a   <= in_a;
                  mac_b   <= in_b;
                  mac_c   <= acc;
                  lat_cnt <= '0;
                  rem     <= rem - LEN_W'(1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt + CNT_W'(1);
               // Last latency cycle: fp_mac Y now holds the issued pair's result.
               if (lat_cnt == LAT_LAST) begin
                  acc   <= mac_y;
                  state <= (rem == '0) ? DONE : ISSUE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_dot_seq.sv
// Randomized bench for fp_dot_seq with a behavioural fp_mac and a real-valued
// dot-product reference restricted to exactly representable operands.
module tb_fp_dot_seq;

   localparam int unsigned MAC_LAT = 3;
   localparam int unsigned LEN_W   = 8;
   localparam int          PER     = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic [31:0]       bias = '0;
   logic              busy;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [15:0]       in_a = '0;
   logic [15:0]       in_b = '0;
   logic [15:0]       mac_a;
   logic [15:0]       mac_b;
   logic [31:0]       mac_c;
   logic [31:0]       mac_y;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_y;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] pa [0:299];
   logic [15:0] pb [0:299];
   logic [31:0] mac_pipe [0:MAC_LAT-2];

   always #(PER/2) clk = ~clk;

   fp_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .bias(bias),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
      .mac_y(mac_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
   );

   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp_val(input logic [31:0] b, input int ew, input int mw);
      int  e;
      int  m;
      int  bs;
      real v;
      bs = (1 << (ew - 1)) - 1;
      e  = int'((b >> mw) & ((32'd1 << ew) - 32'd1));
      m  = int'(b & ((32'd1 << mw) - 32'd1));
      if (e == 0) v = real'(m) * pow2(1 - bs - mw);
      else        v = (pow2(mw) + real'(m)) * pow2(e - bs - mw);
      return b[ew+mw] ? -v : v;
   endfunction

   function automatic logic [31:0] fp_enc(input real x, input int ew, input int mw);
      real         a;
      int          e;
      logic [31:0] r;
      if (x == 0.0) return 32'h0;
      a = (x < 0.0) ? -x : x;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      r = 32'(e + (1 << (ew - 1)) - 1) << mw;
      r = r | 32'($rtoi((a - 1.0) * pow2(mw)));
      if (x < 0.0) r = r | (32'd1 << (ew + mw));
      return r;
   endfunction

   function automatic logic [15:0] h16(input int v);
      logic [31:0] r;
      r = fp_enc(real'(v), 5, 10);
      return r[15:0];
   endfunction

   // Stand-in fp_mac: Y = A*B + C, result visible to the sequencer MAC_LAT edges after issue.
   always @(posedge clk) begin
      mac_pipe[0] <= fp_enc(fp_val({16'h0, mac_a}, 5, 10) * fp_val({16'h0, mac_b}, 5, 10)
                            + fp_val(mac_c, 8, 23), 8, 23);
      for (int i = 1; i < MAC_LAT - 1; i++) mac_pipe[i] <= mac_pipe[i-1];
   end
   assign mac_y = mac_pipe[MAC_LAT-2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mac_a"}, {16'h0, mac_a}, 32'h0);
      check({tag, "_mac_b"}, {16'h0, mac_b}, 32'h0);
      check({tag, "_mac_c"}, mac_c, 32'h0);
      check({tag, "_out_y"}, out_y, 32'h0);
      check({tag, "_flags"}, 32'({busy, in_ready, out_valid}), 32'h0);
   endtask

   task automatic run_job(input int n, input logic [31:0] bias_bits, input int gap,
                          input int hold, input bit collide, output logic [31:0] y);
      real     acc_ref;
      int      k;
      int      budget;
      int      stray;
      longint  t_start, t_hs, t_prev, t_ov, lat_exp;
      bit      ok;
      acc_ref = fp_val(bias_bits, 8, 23);
      k = 0; ok = 1'b1; t_prev = 0; y = 32'h0;
      @(negedge clk);
      start = 1'b1; len = LEN_W'(n); bias = bias_bits;
      in_valid = (n > 0); in_a = pa[0]; in_b = pb[0];
      @(posedge clk);
      t_start = $time;
      @(negedge clk);
      start = 1'b0; len = LEN_W'($urandom); bias = $urandom;
      while (ok && k < n) begin
         budget = 0;
         while (!(in_ready && in_valid) && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         if (budget >= 200) begin
            check("hs_timeout", 32'd0, 32'd1);
            ok = 1'b0;
         end else begin
            @(posedge clk);
            t_hs = $time;
            if (k == 0) check("hs0_time", 32'((t_hs - t_start) / PER), 32'd1);
            else check("hs_spacing", 32'((t_hs - t_prev) / PER),
                       32'((k == 1 && gap > int'(MAC_LAT)) ? gap + 1 : int'(MAC_LAT) + 1));
            t_prev = t_hs;
            @(negedge clk);
            check("mac_a", {16'h0, mac_a}, {16'h0, pa[k]});
            check("mac_b", {16'h0, mac_b}, {16'h0, pb[k]});
            check("mac_c", mac_c, fp_enc(acc_ref, 8, 23));
            acc_ref = acc_ref + fp_val({16'h0, pa[k]}, 5, 10) * fp_val({16'h0, pb[k]}, 5, 10);
            k++;
            if (k == 1 && gap > 0 && n > 1) begin
               in_valid = 1'b0;
               repeat (gap) @(negedge clk);
            end
            // Valid stays high through WAIT/DONE/IDLE with junk data once pairs run out.
            in_valid = 1'b1;
            if (k < n) begin in_a = pa[k]; in_b = pb[k]; end
            else begin in_a = 16'($urandom); in_b = 16'($urandom); end
         end
      end
      budget = 0; stray = 0;
      while (ok && !out_valid && budget < 400) begin
         if (in_ready) stray++;
         @(negedge clk);
         budget++;
      end
      if (ok && !out_valid) check("out_timeout", 32'd0, 32'd1);
      else if (ok) begin
         t_ov = $time - PER/2;
         lat_exp = (n == 0) ? 1 : n * (MAC_LAT + 1) + 1
                   + ((gap > int'(MAC_LAT) && n > 1) ? gap - MAC_LAT : 0);
         check("out_latency", 32'((t_ov - t_start) / PER + 1), 32'(lat_exp));
         check("out_y", out_y, fp_enc(acc_ref, 8, 23));
         check("no_extra_ready", 32'(stray), 32'd0);
         y = out_y;
         for (int i = 0; i < hold; i++) begin
            start = (i == hold / 2);
            len = LEN_W'(5);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_y", out_y, y);
         end
         start = collide; out_ready = 1'b1;
         @(negedge clk);
         start = 1'b0; out_ready = 1'b0;
         check("ret_idle", 32'({busy, out_valid}), 32'd0);
         @(negedge clk);
         check("no_restart", 32'({busy, in_ready}), 32'd0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #(PER * 60000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] y;
      int          hs;
      int          budget;
      int          n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Basic dot product: 1 + 1*2 + 2*3 = 9
      pa[0] = 16'h3C00; pb[0] = 16'h4000; pa[1] = 16'h4000; pb[1] = 16'h4200;
      run_job(2, 32'h3F80_0000, 0, 0, 1'b0, y);
      check("basic_y", y, 32'h4110_0000);

      // Zero length returns the bias directly
      run_job(0, 32'hC0A0_0000, 0, 0, 1'b0, y);
      check("zero_y", y, 32'hC0A0_0000);

      // Input gap before the second pair
      for (int i = 0; i < 3; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h3C00; end
      run_job(3, 32'h0, 5, 0, 1'b0, y);
      check("gap_y", y, 32'h4040_0000);

      // Output backpressure with START pulses and a START/OUT_READY collision
      pa[0] = 16'h4200; pb[0] = 16'h4200;
      run_job(1, 32'h3F80_0000, 0, 10, 1'b1, y);
      check("bp_y", y, 32'h4120_0000);

      // Reset one cycle into WAIT of pair 2 of 4
      for (int i = 0; i < 4; i++) begin pa[i] = 16'h4000; pb[i] = 16'h4200; end
      @(negedge clk);
      start = 1'b1; len = LEN_W'(4); bias = 32'h3F80_0000;
      in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
      @(negedge clk);
      start = 1'b0;
      hs = 0; budget = 0;
      while (hs < 2 && budget < 100) begin
         if (in_ready && in_valid) hs++;
         @(negedge clk);
         budget++;
      end
      check("rst_reach_wait", 32'(hs), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      reset = 1'b0; in_valid = 1'b0;
      pa[0] = 16'h4000; pb[0] = 16'h4000;
      run_job(1, 32'h0, 0, 0, 1'b0, y);
      check("rst_job_y", y, 32'h4080_0000);

      // Randomized jobs over exactly representable small integers
      for (int j = 0; j < 8; j++) begin
         n = int'($urandom_range(0, 6));
         for (int i = 0; i < n; i++) begin
            pa[i] = h16(int'($urandom_range(0, 8)) - 4);
            pb[i] = h16(int'($urandom_range(0, 8)) - 4);
         end
         run_job(n, fp_enc(real'(int'($urandom_range(0, 20)) - 10), 8, 23),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), y);
      end

      // Maximum length: exactly 255 pairs
      for (int i = 0; i < 255; i++) begin
         pa[i] = h16(int'($urandom_range(0, 4)) - 2);
         pb[i] = h16(int'($urandom_range(0, 4)) - 2);
      end
      run_job(255, 32'h3F80_0000, 0, 1, 1'b0, y);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_dot_seq.md
# fp_dot_seq

Upstream sequencer for `fp_mac` that turns a stream of FP16 operand pairs into a single FP32 dot product. It drives `fp_mac` A/B with one pair at a time and C with the running FP32 accumulator. It waits out the MAC pipeline latency, feeds each `fp_mac` Y result back as the next C, and presents the final sum on a valid/ready output.

## Interface
- `MAC_LAT`, default 2: cycles from the `fp_mac` operand-register update edge to the edge where `MAC_Y` holds that result. Legal range ≥1.
- `LEN_W`, default 8: width of the pair-count field.

- `CLK` in 1: clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `START` in 1: begin a dot product. Sampled only in IDLE.
- `LEN` in `LEN_W`: number of pairs. Sampled with `START`.
- `BIAS` in 32: FP32 initial accumulator. Sampled with `START`.
- `BUSY` out 1: high in any state other than IDLE.
- `IN_VALID` in 1, `IN_READY` out 1: operand-pair handshake.
- `IN_A` in 16, `IN_B` in 16: FP16 operands.
- `MAC_A` out 16, `MAC_B` out 16, `MAC_C` out 32: registered drive to `fp_mac` A/B/C.
- `MAC_Y` in 32: `fp_mac` Y.
- `OUT_VALID` out 1, `OUT_READY` in 1: result handshake.
- `OUT_Y` out 32: FP32 dot product.

## Operation
- States:
  - IDLE: waits for `START`.
  - ISSUE: accepts one pair.
  - WAIT: covers the MAC latency.
  - DONE: presents the result.
- Registers:
  - `acc` (32b): running accumulator.
  - `rem` (`LEN_W`): pairs remaining.
  - `lat_cnt`: counts 0..`MAC_LAT`−1.
- IDLE, with `START`=1: load `acc`←`BIAS` and `rem`←`LEN`. Go to DONE if `LEN`=0, otherwise to ISSUE.
- ISSUE:
  - `IN_READY`=1, combinational from the state only, never from `IN_VALID`.
  - On `IN_VALID&IN_READY`: `MAC_A`←`IN_A`, `MAC_B`←`IN_B`, `MAC_C`←`acc`, `lat_cnt`←0, `rem`←`rem`−1, go to WAIT.
- WAIT:
  - `lat_cnt` increments each edge.
  - On the edge where `lat_cnt`=`MAC_LAT`−1: `acc`←`MAC_Y`. Go to DONE if `rem`=0, otherwise to ISSUE.
- DONE:
  - `OUT_VALID`=1 and `OUT_Y`=`acc`, both stable until the handshake.
  - On `OUT_VALID&OUT_READY`: go to IDLE.
- `MAC_A`/`MAC_B`/`MAC_C` hold their last values outside the issue edge.
- No arithmetic in this block. All FP math is in `fp_mac`, and `acc` is a bit-exact copy of `MAC_Y`.

## Timing
- Reset values (all outputs and state):
  - state=IDLE; `acc`, `rem`, `lat_cnt` = 0.
  - `MAC_A`/`MAC_B`/`MAC_C`=0, `OUT_Y`=0.
  - `IN_READY`=0, `OUT_VALID`=0, `BUSY`=0.
- Handshake at edge t: `fp_mac` sees the new operands from t. `acc` captures `MAC_Y` at edge t+`MAC_LAT`.
- ISSUE is entered at t+`MAC_LAT`, so the earliest next handshake is t+`MAC_LAT`+1.
- Throughput: one pair per `MAC_LAT`+1 cycles when `IN_VALID` is held high.
- Latency:
  - `START` edge to `OUT_VALID`: N·(`MAC_LAT`+1)+1 cycles for N≥1 with no input gaps.
  - `LEN`=0: `OUT_VALID` is high the cycle after `START`.
- Boundary conditions:
  - `START` while `BUSY`=1: ignored, with no effect on `LEN`/`BIAS` capture.
  - `IN_VALID`=0 in ISSUE: stall indefinitely. `MAC_*` hold, `acc` unchanged.
  - `IN_VALID` outside ISSUE: ignored, no pair consumed.
  - `OUT_READY`=0 in DONE: stall with `OUT_Y` stable.
  - `OUT_READY` with `START` in the same cycle in DONE: return to IDLE. That `START` is ignored and must be reasserted.
  - `RESET` mid-operation: all state returns to reset values at that edge. The partial sum is discarded, and any in-flight `fp_mac` result is ignored.
  - `LEN` at maximum (2^`LEN_W`−1): processes exactly that many pairs. `rem` never wraps.

## Structure
- Shared package `fp_mac_pkg`:
  - Width constants: `FP16_W`=16, `FP32_W`=32.
  - State enum `dot_state_t` {IDLE, ISSUE, WAIT, DONE}.
  - FP constants `FP32_ZERO`, `FP32_ONE`=0x3F800000.
- No sub-module. The latency counter and FSM are inline.
- `fp_mac` is instantiated beside this block in the parent, not inside it.

## Test plan
All scenarios use a real `fp_mac` with `MAC_LAT` matched to it.
- Basic dot product:
  - Stimulus: `LEN`=2, `BIAS`=0x3F800000, pairs (0x3C00,0x4000) then (0x4000,0x4200).
  - Response: one `OUT_VALID` with `OUT_Y`=0x41100000 (1+2+6=9). `MAC_C` is 0x3F800000 on the first issue and 0x40400000 on the second.
- Zero length:
  - Stimulus: `LEN`=0, `BIAS`=0xC0A00000.
  - Response: `OUT_VALID` the next cycle with `OUT_Y`=0xC0A00000. `IN_READY` never high.
- Input gaps and throughput:
  - Stimulus: `LEN`=3, all pairs (0x3C00,0x3C00), `BIAS`=0. `IN_VALID` is dropped for 5 cycles before the second pair.
  - Response: `OUT_Y`=0x40400000. Handshakes are spaced exactly `MAC_LAT`+1 cycles apart, except the 5-cycle gap.
- Output backpressure and START collision:
  - Stimulus: hold `OUT_READY`=0 for 10 cycles in DONE and pulse `START` during that time.
  - Response: `OUT_Y` stable, `BUSY`=1, `START` ignored. After `OUT_READY` rises: IDLE the next cycle, with no new job started.
- Reset mid-job:
  - Stimulus: assert `RESET` one cycle into WAIT of pair 2 of 4, then start a new job with `LEN`=1, `BIAS`=0, pair (0x4000,0x4000).
  - Response: all outputs at reset values the cycle after reset. The new job gives `OUT_Y`=0x40800000.
